// File: rtl/ft_cmd_parser.sv
// ft_cmd_parser: FT245 byte-stream to register-bus command decoder; CMD_ACK_EN adds a write-ack echo byte
module ft_cmd_parser #(
  parameter int DATA_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_rdata,
  input  logic                    rx_rempty,
  output logic                    rx_rinc,
  output logic [7:0]              tx_wdata,
  input  logic                    tx_wfull,
  output logic                    tx_winc,
  output logic [5:0]              reg_addr,
  output logic [8*DATA_BYTES-1:0] reg_wdata,
  output logic                    reg_we,
  output logic                    reg_re,
  input  logic [8*DATA_BYTES-1:0] reg_rdata,
  output logic [7:0]              err_count
);
  localparam int W  = 8*DATA_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYCLES)+1;
  localparam int IW = $clog2(DATA_BYTES+1)+1;
  typedef enum logic [2:0] {
    IDLE, WDATA, WRITE, RREQ, RWAIT, RESP
`ifdef CMD_ACK_EN
    , ACK
`endif
  } state_t;
  state_t state;
  logic [7:0] hdr;
  logic [IW-1:0] idx;
  logic [TW-1:0] tcnt;
  logic [W-1:0] resp;
  logic illegal, tmo;
  assign rx_rinc = rst_n && (state == IDLE || state == WDATA) && !rx_rempty;
`ifdef CMD_ACK_EN
  assign tx_winc = (state == RESP || state == ACK) && !tx_wfull;
`else
  assign tx_winc = state == RESP && !tx_wfull;
`endif
  assign reg_we  = state == WRITE;
  assign reg_re  = state == RREQ;
  assign illegal = state == IDLE && rx_rinc && rx_rdata[7:6] == 2'b11;
  assign tmo     = state == WDATA && !rx_rinc && tcnt == TW'(TIMEOUT_CYCLES-1);
  // command FSM: header decode, data gathering, register strobes, response streaming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hdr       <= '0;
      idx       <= '0;
      tcnt      <= '0;
      resp      <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      tx_wdata  <= '0;
      err_count <= '0;
    end else begin
      if ((illegal || tmo) && err_count != 8'hFF) err_count <= err_count + 8'd1;
      case (state)
        IDLE: if (rx_rinc) begin
          hdr      <= rx_rdata;
          reg_addr <= rx_rdata[5:0];
          idx      <= '0;
          tcnt     <= '0;
          state    <= rx_rdata[7:6] == 2'b01 ? WDATA : rx_rdata[7:6] == 2'b10 ? RREQ : IDLE;
        end
        WDATA: if (rx_rinc) begin
          reg_wdata <= (reg_wdata << 8) | W'(rx_rdata);
          tcnt      <= '0;
          idx       <= idx + 1'b1;
          if (idx == IW'(DATA_BYTES-1)) state <= WRITE;
        end else if (tmo) begin
          state <= IDLE;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
`ifdef CMD_ACK_EN
        WRITE: begin
          tx_wdata <= hdr;
          state    <= ACK;
        end
        ACK: if (tx_winc) state <= IDLE;
`else
        WRITE: state <= IDLE;
`endif
        RREQ: state <= RWAIT;
        RWAIT: begin
          resp     <= reg_rdata;
          tx_wdata <= hdr;
          idx      <= '0;
          state    <= RESP;
        end
        RESP: if (tx_winc) begin
          tx_wdata <= resp[W-1 -: 8];
          resp     <= resp << 8;
          idx      <= idx + 1'b1;
          if (idx == IW'(DATA_BYTES)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ft_cmd_parser.md
Name: ft_cmd_parser

Overview:
- Byte-stream command decoder downstream of the FT245 RX FIFO and upstream of the FT245 TX FIFO.
- Pops host bytes from the RX FIFO read side and turns them into register-bus writes and reads for the CCD controller register file.
- Pushes read responses, and optionally write acks, into the TX FIFO write side.
- Runs in the system clock domain. The FIFOs handle the crossing from ft_clkout.

Parameters:
- DATA_BYTES, 2, register width in bytes; register data width is 8*DATA_BYTES.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes of one command before it is aborted.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_rdata  input  8  RX FIFO head byte; first-word-fall-through, valid while rx_rempty=0
- rx_rempty  input  1  RX FIFO empty
- rx_rinc  output  1  pop RX FIFO head this cycle
- tx_wdata  output  8  byte to TX FIFO
- tx_wfull  input  1  TX FIFO full
- tx_winc  output  1  push tx_wdata this cycle
- reg_addr  output  6  register address
- reg_wdata  output  8*DATA_BYTES  register write data
- reg_we  output  1  one-cycle write strobe
- reg_re  output  1  one-cycle read strobe
- reg_rdata  input  8*DATA_BYTES  read data, valid exactly 1 cycle after reg_re
- err_count  output  8  saturating protocol-error counter

Behaviour:
- Async reset values:
  - state=IDLE; all strobes (rx_rinc, tx_winc, reg_we, reg_re) = 0.
  - reg_addr=0, reg_wdata=0, tx_wdata=0, err_count=0.
  - A reset mid-command discards all partial bytes.
- Header byte format: [7:6] opcode, [5:0] address.
  - 00 = NOP.
  - 01 = WRITE; followed by DATA_BYTES data bytes, MSB first.
  - 10 = READ.
  - 11 = illegal.
- rx_rinc is combinational: (state==IDLE or state==WDATA) and rx_rempty==0. A byte is consumed in the same cycle it is accepted.
- tx_winc is combinational: (state==RESP or state==ACK) and tx_wfull==0.
- States:
  - IDLE: on a popped byte, latch the header and reg_addr.
    - NOP: stay in IDLE.
    - WRITE: go to WDATA with byte counter=0.
    - READ: go to RREQ.
    - Illegal: stay in IDLE and increment err_count.
  - WDATA: each popped byte shifts into reg_wdata from the LSB end, so the first byte ends up as the MSB. After the DATA_BYTES-th byte, go to WRITE.
  - WRITE: reg_we=1 for exactly one cycle. Next state is ACK if CMD_ACK_EN is defined, else IDLE.
  - RREQ: reg_re=1 for one cycle, then go to RWAIT.
  - RWAIT: capture reg_rdata into the response register. Go to RESP with byte index 0.
  - RESP: emit DATA_BYTES+1 bytes in order: header echo, then data MSB first. Advance the index only on cycles where tx_winc=1. Stall indefinitely while tx_wfull=1. After the last byte, go to IDLE.
  - ACK: emit one byte, the header echo, when tx_wfull==0, then go to IDLE.
- Timeout:
  - Counter runs only in WDATA. It clears on every popped byte and increments otherwise.
  - At TIMEOUT_CYCLES-1 it aborts to IDLE, increments err_count, and issues no reg_we.
  - Counter width is clog2(TIMEOUT_CYCLES)+1.
- err_count saturates at 255. If a timeout and an illegal opcode fall in the same cycle (impossible by construction), it still increments by 1 only.
- Latencies:
  - READ: reg_re asserts 1 cycle after the header pop; the first response byte can be pushed 3 cycles after the header pop.
  - WRITE: reg_we asserts 1 cycle after the last data byte pop.
- Backpressure: no RX bytes are popped while in WRITE, RREQ, RWAIT, RESP or ACK. RX and TX traffic are strictly serialized.

Optional Feature:
- Macro: CMD_ACK_EN.
- Defined: each completed WRITE is followed by the ACK state, pushing the header echo byte, e.g. 0x45 for a write to address 5.
- Undefined: the ACK state and its logic are absent, WRITE returns directly to IDLE, and writes produce no TX traffic.

Test Plan:
- Write: RX bytes 0x45,0x12,0x34 back-to-back, DATA_BYTES=2 → one reg_we pulse with reg_addr=5, reg_wdata=0x1234; no tx_winc (or a single 0x45 push with CMD_ACK_EN).
- Read: RX 0x8A, reg_rdata=0xBEEF one cycle after reg_re → tx pushes 0x8A,0xBE,0xEF in order; reg_re high exactly one cycle.
- TX backpressure: read command with tx_wfull held high 10 cycles after the first push → exactly 3 pushes total, no duplicates or drops, rx_rinc=0 throughout.
- Illegal/NOP: RX 0xC0,0x00,0x81 → err_count=1, NOP ignored, read of address 1 serviced normally.
- Timeout: TIMEOUT_CYCLES=16, RX 0x45,0x12 then starve → abort after 16 idle cycles, err_count=1, no reg_we; following 0x81 is parsed as a fresh header.
- Reset mid-operation: assert rst_n=0 during RESP after 1 byte pushed → all outputs 0 immediately; after release the next bytes parse from IDLE.
